// File: rtl/uart_pkg.sv
// Shared UART definitions: controller state encoding and bit-timing helpers.
// Used by both the receive and transmit controllers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit period.
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Delay from a detected start edge to the start-bit mid-point.
    function automatic int uart_half(input int clk_freq, input int baud);
        return uart_div(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/baudgen.sv
// Baud tick generator. The counter is held at zero while en is low, so the
// first tick lands exactly one bit period after en rises and every bit period
// after that.
module baudgen
    import uart_pkg::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic baud_tick
);

    localparam int DIV   = uart_div(clk_freq, baud);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: cleared while disabled, wraps after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Bit-period counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign baud_tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receive controller, LSB first. Finds the start-bit mid-point with
// a half-bit counter, then enables the baud generator so each tick falls
// mid-bit. Good bytes are presented on data with a one-cycle data_valid;
// frames with a low stop bit only pulse frame_err and leave data untouched.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int clk_freq = 12000000,
    parameter int baud     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV    = uart_div(clk_freq, baud);
    localparam int HALF   = uart_half(clk_freq, baud);
    localparam int HALF_W = $clog2(HALF + 1);
    localparam logic [HALF_W-1:0] HALF_CNT = HALF_W'(HALF);

    logic              rx_sync1_q;
    logic              rx_s_q;
    logic              rx_prev_q;
    uart_state_e       state_q, state_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        data_sr_q, data_sr_d;
    logic [7:0]        data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              en_q, en_d;
    logic              baud_tick;
    logic              start_det;

    baudgen #(
        .clk_freq(clk_freq),
        .baud    (baud)
    ) u_baudgen (
        .clk      (clk),
        .rst      (rst),
        .en       (en_q),
        .baud_tick(baud_tick)
    );

    // Two-flop synchroniser plus one history flop for falling-edge detection;
    // all load 1 (idle line) on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync1_q <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= rx;
            rx_s_q     <= rx_sync1_q;
            rx_prev_q  <= rx_s_q;
        end
    end

    assign start_det = rx_prev_q && !rx_s_q;

    // Receive FSM: next state, shift register, and output pulses.
    always_comb begin
        state_d      = state_q;
        half_cnt_d   = half_cnt_q;
        bitcnt_d     = bitcnt_q;
        data_sr_d    = data_sr_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d    = START;
                    half_cnt_d = '0;
                end
            end
            START: begin
                if (half_cnt_q == HALF_CNT) begin
                    // A high line at the start-bit mid-point was only a glitch.
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            DATA: begin
                if (baud_tick) begin
                    data_sr_d = {rx_s_q, data_sr_q[7:1]};
                    bitcnt_d  = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (rx_s_q) begin
                        data_d       = data_sr_q;
                        data_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        en_d = (state_d == DATA) || (state_d == STOP);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            half_cnt_q   <= '0;
            bitcnt_q     <= '0;
            data_sr_q    <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            bitcnt_q     <= bitcnt_d;
            data_sr_q    <= data_sr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            en_q         <= en_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    // The FSM is already back in IDLE during the pulse cycle, so the pulses
    // keep busy high through the end of the frame.
    assign busy       = (state_q != IDLE) || data_valid_q || frame_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl at DIV=10, HALF=5. The driver serialises frames
// and pushes the expected outcome ({is_err, data}) into a queue; a monitor
// pops and compares whenever the DUT pulses data_valid or frame_err.
module tb_uart_rx_ctrl;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int HALF     = DIV / 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: expected pulses and the last good byte delivered.
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int start_cyc = 0;
    int exp_lat = -1;

    // Busy-gap watcher for back-to-back frames.
    bit gap_watch = 0;
    bit gap_open = 0;
    int gap_cnt = 0;
    int gap_max = 0;
    int dv_seen = 0;

    uart_rx_ctrl #(
        .clk_freq(CLK_FREQ),
        .baud    (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err)) begin
            chk("pulse_exclusive", int'(data_valid && frame_err), 0);
            if (data_valid) dv_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("pulse_kind", int'(frame_err), int'(e[8]));
                chk("pulse_data", int'(data), int'(e[7:0]));
                if (exp_lat >= 0) begin
                    chk("latency", cyc - start_cyc, exp_lat);
                    exp_lat = -1;
                end
            end
        end
    end

    // Back-to-back watcher: length of the busy-low gap after a data_valid.
    always @(negedge clk) begin
        if (gap_watch) begin
            if (data_valid) begin
                gap_open = 1;
                gap_cnt = 0;
            end else if (gap_open) begin
                if (!busy) begin
                    gap_cnt++;
                end else begin
                    gap_open = 0;
                    if (gap_cnt > gap_max) gap_max = gap_cnt;
                end
            end
        end
    end

    // Driver tasks; all start and end on a falling clock edge.
    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit want_lat);
        logic [9:0] bits;
        if (stop_ok) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        bits = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == 0 && want_lat) begin
                start_cyc = cyc + 1;
                exp_lat = 2 + HALF + 9 * DIV + 1;
            end
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    // Stimulus sequence.
    initial begin
        logic [7:0] held;
        rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_data", int'(data), 0);
        chk("reset_valid", int'(data_valid), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_busy", int'(busy), 0);
        rst = 1'b0;
        idle(5);

        // Single good frame with latency measurement.
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(5);
        drain();
        chk("a5_data_held", int'(data), 'hA5);

        // Back-to-back frames with no idle gap.
        gap_watch = 1;
        gap_max = 0;
        dv_seen = 0;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(5);
        drain();
        gap_watch = 0;
        chk("b2b_valid_count", dv_seen, 2);
        // Re-arm delay is the synchroniser plus the edge detector.
        chk("b2b_busy_gap_ok", int'(gap_max <= 3), 1);

        // Glitch: three low cycles, then high.
        held = last_good;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_start", int'(busy), 1);
        idle(HALF + 8);
        chk("glitch_busy_end", int'(busy), 0);
        chk("glitch_data", int'(data), int'(held));

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(5);
        drain();
        chk("ferr_data_kept", int'(data), int'(held));

        // Reset in the middle of the data bits.
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (DIV + 3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_data", int'(data), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(data_valid), 0);
        last_good = 8'h00;
        exp_q.delete();
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(5);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(5);
        drain();

        // Break: line low for 30 bit times, one frame_err expected.
        exp_q.push_back({1'b1, last_good});
        rx = 1'b0;
        repeat (30 * DIV) @(negedge clk);
        idle(3 * DIV);
        drain();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(5);
        drain();
        chk("break_then_data", int'(data), 'h81);

        // Randomised frames: random bytes, occasional bad stop, random gaps.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            bit ok;
            b = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok, 1'b0);
            // After a low stop bit the line must be seen high before the next start edge.
            if (ok) idle($urandom_range(0, 3));
            else idle($urandom_range(3, 6));
        end
        idle(5);
        drain();
        chk("final_data", int'(data), int'(last_good));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
